// File: rtl/sponge_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sponge_ctrl
// Description : Sponge sequencer for the SHAKE core. Handles the command,
//               input-word and output-word handshakes and drives lane-indexed
//               clear/absorb/pad/round strobes to the state datapath.
//               Optional macro SPONGE_ABORT_EN enables abort_i.
// Revision    : 1.0 - initial release
// ============================================================================
module sponge_ctrl #(
   parameter  int WORD_W      = 64,
   parameter  int RATE0_WORDS = 21,
   parameter  int RATE1_WORDS = 17,
   parameter  int ROUNDS      = 24,
   parameter  int LEN_W       = 32,
   localparam int RATE_MAX    = (RATE0_WORDS > RATE1_WORDS) ? RATE0_WORDS : RATE1_WORDS,
   localparam int LANE_W      = $clog2(RATE_MAX),
   localparam int RND_W       = $clog2(ROUNDS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   output logic              start_ready_o,
   input  logic              mode_i,
   input  logic [LEN_W-1:0]  in_words_i,
   input  logic [LEN_W-1:0]  out_words_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic              out_last_o,
   output logic              state_clear_o,
   output logic              absorb_we_o,
   output logic              pad_o,
   output logic [LANE_W-1:0] lane_idx_o,
   output logic              round_en_o,
   output logic [RND_W-1:0]  round_idx_o,
   output logic              busy_o,
   output logic              done_o,
   input  logic              abort_i
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ABSORB  = 3'd1,
      S_PAD     = 3'd2,
      S_PERMUTE = 3'd3,
      S_SQUEEZE = 3'd4
   } state_t;

   localparam logic [LANE_W-1:0] RATE0_M1 = LANE_W'(RATE0_WORDS - 1);
   localparam logic [LANE_W-1:0] RATE1_M1 = LANE_W'(RATE1_WORDS - 1);
   localparam logic [RND_W-1:0]  RND_LAST = RND_W'(ROUNDS - 1);

   state_t             state, state_n;
   logic [LANE_W-1:0]  lane, lane_n;
   logic [LANE_W-1:0]  rate_m1, rate_m1_n;
   logic [LEN_W-1:0]   in_rem, in_rem_n;
   logic [LEN_W-1:0]   out_rem, out_rem_n;
   logic               padded, padded_n;
   logic [RND_W-1:0]   rnd, rnd_n;
   logic               clear_n, done_n;
   logic               abort_req;
   logic               in_hs, out_hs, cmd_hs;
   logic               unused_cfg;

`ifdef SPONGE_ABORT_EN
   assign abort_req  = abort_i && (state != S_IDLE);
   assign unused_cfg = (WORD_W > 0);
`else
   assign abort_req  = 1'b0;
   assign unused_cfg = (WORD_W > 0) ^ abort_i;
`endif

   // Handshake-facing outputs decoded from state; abort suppresses acceptance
   assign start_ready_o = (state == S_IDLE);
   assign in_ready_o    = (state == S_ABSORB) && (in_rem != '0) && !abort_req;
   assign absorb_we_o   = in_valid_i && in_ready_o;
   assign out_valid_o   = (state == S_SQUEEZE) && !abort_req;
   assign out_last_o    = out_valid_o && (out_rem == LEN_W'(1));
   assign in_hs         = absorb_we_o;
   assign out_hs        = out_valid_o && out_ready_i;
   assign cmd_hs        = start_i && start_ready_o;

   // Next-state and next-counter logic for the sponge sequence
   always_comb begin
      state_n   = state;
      lane_n    = lane;
      rate_m1_n = rate_m1;
      in_rem_n  = in_rem;
      out_rem_n = out_rem;
      padded_n  = padded;
      rnd_n     = rnd;
      clear_n   = 1'b0;
      done_n    = 1'b0;
      if (abort_req) begin
         state_n = S_IDLE;
         lane_n  = '0;
         rnd_n   = '0;
         clear_n = 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_hs) begin
                  rate_m1_n = mode_i ? RATE1_M1 : RATE0_M1;
                  in_rem_n  = in_words_i;
                  out_rem_n = out_words_i;
                  lane_n    = '0;
                  padded_n  = 1'b0;
                  clear_n   = 1'b1;
                  state_n   = S_ABSORB;
               end
            end
            S_ABSORB: begin
               if (in_hs) begin
                  in_rem_n = in_rem - LEN_W'(1);
                  lane_n   = lane + 1'b1;
                  if (lane == rate_m1) begin
                     lane_n  = '0;
                     rnd_n   = '0;
                     state_n = S_PERMUTE;
                  end else if (in_rem == LEN_W'(1)) begin
                     state_n = S_PAD;
                  end
               end else if (in_rem == '0) begin
                  state_n = S_PAD;
               end
            end
            S_PAD: begin
               padded_n = 1'b1;
               lane_n   = '0;
               rnd_n    = '0;
               state_n  = S_PERMUTE;
            end
            S_PERMUTE: begin
               rnd_n = rnd + 1'b1;
               if (rnd == RND_LAST) begin
                  rnd_n = '0;
                  if (!padded) begin
                     state_n = S_ABSORB;
                  end else if (out_rem != '0) begin
                     state_n = S_SQUEEZE;
                  end else begin
                     done_n  = 1'b1;
                     state_n = S_IDLE;
                  end
               end
            end
            S_SQUEEZE: begin
               if (out_hs) begin
                  out_rem_n = out_rem - LEN_W'(1);
                  lane_n    = lane + 1'b1;
                  if (out_rem == LEN_W'(1)) begin
                     lane_n  = '0;
                     done_n  = 1'b1;
                     state_n = S_IDLE;
                  end else if (lane == rate_m1) begin
                     lane_n  = '0;
                     rnd_n   = '0;
                     state_n = S_PERMUTE;
                  end
               end
            end
            default: begin
               state_n = S_IDLE;
               lane_n  = '0;
               rnd_n   = '0;
            end
         endcase
      end
   end

   // State, counters and registered strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         lane          <= '0;
         rate_m1       <= '0;
         in_rem        <= '0;
         out_rem       <= '0;
         padded        <= 1'b0;
         rnd           <= '0;
         state_clear_o <= 1'b0;
         done_o        <= 1'b0;
         pad_o         <= 1'b0;
         round_en_o    <= 1'b0;
         busy_o        <= 1'b0;
      end else begin
         state         <= state_n;
         lane          <= lane_n;
         rate_m1       <= rate_m1_n;
         in_rem        <= in_rem_n;
         out_rem       <= out_rem_n;
         padded        <= padded_n;
         rnd           <= rnd_n;
         state_clear_o <= clear_n;
         done_o        <= done_n;
         pad_o         <= (state_n == S_PAD);
         round_en_o    <= (state_n == S_PERMUTE);
         busy_o        <= (state_n != S_IDLE);
      end
   end

   assign lane_idx_o  = lane;
   assign round_idx_o = rnd;

endmodule
`default_nettype wire

// File: tb/tb_sponge_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sponge_ctrl
// Description : Self-checking bench for sponge_ctrl: table of transactions
//               with hand-computed strobe counts, plus reset/abort sequences.
//               Abort sequence compiled in with SPONGE_ABORT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sponge_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_i = 1'b0;
   logic        start_ready_o;
   logic        mode_i = 1'b0;
   logic [31:0] in_words_i = '0;
   logic [31:0] out_words_i = '0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic        out_valid_o;
   logic        out_ready_i = 1'b0;
   logic        out_last_o;
   logic        state_clear_o;
   logic        absorb_we_o;
   logic        pad_o;
   logic [4:0]  lane_idx_o;
   logic        round_en_o;
   logic [4:0]  round_idx_o;
   logic        busy_o;
   logic        done_o;
   logic        abort_i = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   sponge_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .start_ready_o(start_ready_o),
      .mode_i(mode_i), .in_words_i(in_words_i), .out_words_i(out_words_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i), .out_last_o(out_last_o), .state_clear_o(state_clear_o),
      .absorb_we_o(absorb_we_o), .pad_o(pad_o), .lane_idx_o(lane_idx_o),
      .round_en_o(round_en_o), .round_idx_o(round_idx_o), .busy_o(busy_o),
      .done_o(done_o), .abort_i(abort_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic mode;
      int   in_w;
      int   out_w;
      logic gaps;
      int   exp_abs;
      int   exp_pad_lane;
      int   exp_rnd;
      int   exp_sq;
   } vec_t;

   vec_t tbl [6];
   logic abort_noise;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Outputs with no transaction in flight
   task automatic chk_idle(input string tag);
      chk({tag, " start_ready"}, start_ready_o, 1);
      chk({tag, " busy"}, busy_o, 0);
      chk({tag, " strobes"}, {state_clear_o, absorb_we_o, pad_o, round_en_o, done_o}, 0);
      chk({tag, " handshake outs"}, {in_ready_o, out_valid_o, out_last_o}, 0);
      chk({tag, " lane/round idx"}, {lane_idx_o, round_idx_o}, 0);
   endtask

   // Issue a command; the handshake happens on the following rising edge
   task automatic issue(input logic m, input int iw, input int ow);
      @(negedge clk);
      start_i     = 1'b1;
      mode_i      = m;
      in_words_i  = iw;
      out_words_i = ow;
   endtask

   // Run one table transaction, checking every strobe cycle by cycle
   task automatic run_vec(input int k, input vec_t v);
      int   rate, n_abs, n_pad, pad_lane, n_rnd, n_sq, n_clr, n_done;
      logic fin, stall_prev;
      int   stall_lane;
      string tg;
      tg = $sformatf("vec%0d", k);
      rate = v.mode ? 17 : 21;
      n_abs = 0; n_pad = 0; pad_lane = -1; n_rnd = 0; n_sq = 0; n_clr = 0; n_done = 0;
      fin = 1'b0; stall_prev = 1'b0; stall_lane = 0;
      issue(v.mode, v.in_w, v.out_w);
      abort_i = abort_noise;
      for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
         @(negedge clk);
         start_i     = (cyc == 10);
         mode_i      = ~v.mode;
         in_valid_i  = v.gaps ? (cyc % 3 != 1) : 1'b1;
         out_ready_i = v.gaps ? cyc[0] : 1'b1;
         #1;
         if (stall_prev) begin
            chk({tg, " stall hold valid"}, out_valid_o, 1);
            chk({tg, " stall hold lane"}, lane_idx_o, stall_lane);
         end
         if (state_clear_o) n_clr++;
         if (absorb_we_o) begin
            chk({tg, " absorb lane"}, lane_idx_o, n_abs % rate);
            n_abs++;
         end
         if (pad_o) begin
            n_pad++;
            pad_lane = lane_idx_o;
         end
         if (round_en_o) begin
            chk({tg, " round idx"}, round_idx_o, n_rnd % 24);
            n_rnd++;
         end
         if (out_valid_o && out_ready_i) begin
            chk({tg, " squeeze lane"}, lane_idx_o, n_sq % rate);
            chk({tg, " out_last"}, out_last_o, (n_sq == v.exp_sq - 1) ? 1 : 0);
            n_sq++;
         end
         stall_prev = out_valid_o && !out_ready_i;
         stall_lane = lane_idx_o;
         if (done_o) begin
            n_done++;
            fin = 1'b1;
            chk({tg, " busy at done"}, busy_o, 0);
            chk({tg, " start_ready at done"}, start_ready_o, 1);
         end
      end
      start_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0; abort_i = 1'b0;
      chk({tg, " finished in budget"}, fin, 1);
      chk({tg, " absorbs"}, n_abs, v.exp_abs);
      chk({tg, " pad count"}, n_pad, 1);
      chk({tg, " pad lane"}, pad_lane, v.exp_pad_lane);
      chk({tg, " round_en cycles"}, n_rnd, v.exp_rnd);
      chk({tg, " squeezes"}, n_sq, v.exp_sq);
      chk({tg, " state_clear count"}, n_clr, 1);
      chk({tg, " done count"}, n_done, 1);
      @(negedge clk); #1;
      chk_idle({tg, " post"});
   endtask

   initial begin
      //         mode  in  out gaps  abs padL rnd  sq
      tbl[0] = '{1'b0,  0,  1, 1'b0,  0,  0,  24,  1};
      tbl[1] = '{1'b0, 21,  4, 1'b0, 21,  0,  48,  4};
      tbl[2] = '{1'b1, 16, 40, 1'b0, 16, 16,  72, 40};
      tbl[3] = '{1'b0, 25, 30, 1'b1, 25,  4,  72, 30};
      tbl[4] = '{1'b1, 17, 17, 1'b1, 17,  0,  48, 17};
      tbl[5] = '{1'b0, 20,  0, 1'b0, 20, 20,  24,  0};
`ifdef SPONGE_ABORT_EN
      abort_noise = 1'b0;
`else
      abort_noise = 1'b1;
`endif

      // Reset state
      repeat (3) @(negedge clk);
      #1 chk_idle("in reset");
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk_idle("after reset");

      for (int k = 0; k < 6; k++) run_vec(k, tbl[k]);

      // Reset asserted in the middle of PERMUTE
      begin
         logic seen;
         seen = 1'b0;
         issue(1'b0, 0, 1);
         for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            start_i = 1'b0;
            #1 if (round_en_o) seen = 1'b1;
         end
         chk("reach PERMUTE", seen, 1);
         repeat (5) @(negedge clk);
         #1 chk("busy before reset", busy_o, 1);
         rst_n = 1'b0;
         #1 chk_idle("mid-permute reset");
         @(negedge clk);
         rst_n = 1'b1;
         #1 chk_idle("reset released");
      end
      run_vec(6, tbl[0]);

`ifdef SPONGE_ABORT_EN
      // Abort at squeeze word 3 (zero-based)
      begin
         int   sq;
         logic hit;
         sq = 0; hit = 1'b0;
         issue(1'b0, 0, 8);
         for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clk);
            start_i = 1'b0;
            out_ready_i = 1'b1;
            #1;
            if (out_valid_o) begin
               if (sq == 3) begin
                  hit = 1'b1;
                  chk("lane at abort", lane_idx_o, 3);
                  abort_i = 1'b1;
                  #1 chk("out_valid forced low", out_valid_o, 0);
               end else begin
                  sq++;
               end
            end
         end
         chk("abort point reached", hit, 1);
         @(negedge clk);
         abort_i = 1'b0;
         out_ready_i = 1'b0;
         #1;
         chk("abort idle", busy_o, 0);
         chk("abort clear pulse", state_clear_o, 1);
         chk("abort no done", done_o, 0);
         chk("abort start_ready", start_ready_o, 1);
         @(negedge clk); #1;
         chk_idle("after abort");
      end
      run_vec(7, tbl[1]);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
